sram_ctrl_ws: RTL and testbench
===============================

Name: sram_ctrl_ws

Overview:
- Parametrised asynchronous-SRAM controller for the TSConf DRAM/SRAM subsystem; successor to the fixed 16-bit, fixed-timing SRAM sequencer.
- Accepts one request per cyc slot from the DRAM arbiter.
- Generates SRAM address, data drive, per-lane WE/RD strobes with programmable read/write wait states and bus turnaround.
- Returns read data with a valid pulse.

Parameters:
AW, 21, SRAM address width (word address).
DW, 16, data width; must be a multiple of 8; BW = DW/8 byte lanes.
RD_WS, 2, extra read wait cycles (0..15); RD strobe width = RD_WS+1 cycles.
WR_WS, 1, extra write wait cycles (0..15); WE strobe width = WR_WS+1 cycles.
TURN, 1, idle turnaround cycles after every access (0..15).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
cyc  in  1  arbiter slot strobe; request sampled only when high
req  in  1  access request; held by master until ack
rnw  in  1  1 = read, 0 = write
addr  in  AW  word address
wrdata  in  DW  write data
bsel  in  BW  positive byte-lane enables for write (bit i -> wrdata[8i+7:8i])
ack  out  1  one-cycle pulse: request accepted, inputs latched
rd_valid  out  1  one-cycle pulse: rddata updated
rddata  out  DW  read data, held until next read completes
busy  out  1  high whenever state != IDLE
sram_addr  out  AW  SRAM address
sram_dq  inout  DW  SRAM data bus; Z unless driving write
sram_we_n  out  BW  per-lane write strobe, active-low
sram_rd_n  out  BW  per-lane read strobe, active-low

Behaviour:
- Reset (rst_n low, any time, including mid-access): state IDLE, sram_addr 0, sram_we_n/sram_rd_n all 1, data drive off (sram_dq Z), rddata 0, ack 0, rd_valid 0, wait counter 0. No strobe glitch; outputs are registers.
- All outputs registered; ack and rd_valid default 0 every cycle.
- States: IDLE, RD, WSETUP, WPULSE, WHOLD, TURN.
- IDLE: if cyc & req at edge E0: latch addr/wrdata/bsel/rnw; ack=1 for the cycle after E0; sram_addr<=addr.
  - rnw=1: go to RD; sram_rd_n all 0; counter=RD_WS.
  - rnw=0: go to WSETUP; start driving sram_dq with wrdata; we_n stays all 1.
  - req without cyc: ignored; no ack.
- RD: counter decrements each cycle. At the edge where counter==0: rddata<=sram_dq, rd_valid=1, sram_rd_n all 1, go to TURN (or IDLE if TURN=0).
  - rd_valid is high in the cycle after edge E0+RD_WS+1. RD_WS=2 -> E0+3.
  - Reads always enable all lanes; bsel is ignored.
- WSETUP: one cycle. Next edge: sram_we_n<=~bsel_latched, counter=WR_WS, go to WPULSE.
- WPULSE: at the edge where counter==0: we_n all 1, go to WHOLD; data still driven.
- WHOLD: one cycle. Next edge: release drive, go to TURN/IDLE.
  - Write occupancy = WR_WS+3 cycles + TURN.
  - Address and data are stable for the whole write, including one cycle before and after WE.
- Write with bsel all 0: full sequence runs and ack is returned; no WE lane asserted.
- TURN: TURN cycles with no acceptance, then IDLE. Earliest next accept is the edge after TURN ends. Back-to-back read->write never overlaps rd_n low with dq drive.
- Counters are 4-bit; no wrap since values are <= 15.
- busy: registered, equals state != IDLE. It is low in the IDLE cycle in which a request is accepted.

Test Plan:
- Reset mid-write (assert rst_n low during WPULSE) -> next cycle we_n=2'b11, dq Z, busy 0, rddata 0; clean accept afterwards.
- Read, defaults, addr=21'h1ABCD, SRAM model returns 16'hBEEF -> ack at E0+1; rd_n=00 for exactly 3 cycles; rd_valid at E0+3; rddata=16'hBEEF; busy high for 4 cycles (RD 3 + TURN 1).
- Write addr=21'h00010, wrdata=16'h1234, bsel=2'b10 -> dq driven 4 cycles; we_n=2'b01 for 2 cycles, with 1 cycle of setup and 1 cycle of hold; model stores only upper byte 8'h12.
- req held with cyc low for 5 cycles, then cyc pulses -> exactly one ack, in the cycle after the cyc edge.
- Back-to-back read then write with TURN=0, RD_WS=0 -> no cycle has any rd_n low while dq is driven; write accepted the edge after rd_valid's edge.
- DW=32, RD_WS=5, WR_WS=0: bsel=4'b0101 -> we_n=4'b1010 for 1 cycle; read latency E0+6.

Source files
------------

// File: rtl/sram_ctrl_ws.sv
// Asynchronous SRAM controller with programmable read/write wait states and bus turnaround.
// Accepts one arbiter request per cyc slot; every output, strobes included, comes straight from a register.
module sram_ctrl_ws #(
    parameter  int AW    = 21,
    parameter  int DW    = 16,
    parameter  int RD_WS = 2,
    parameter  int WR_WS = 1,
    parameter  int TURN  = 1,
    localparam int BW    = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cyc,
    input  logic          req,
    input  logic          rnw,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wrdata,
    input  logic [BW-1:0] bsel,
    output logic          ack,
    output logic          rd_valid,
    output logic [DW-1:0] rddata,
    output logic          busy,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_dq,
    output logic [BW-1:0] sram_we_n,
    output logic [BW-1:0] sram_rd_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_TURN
    } state_t;

    localparam logic [3:0] RD_CNT   = 4'(RD_WS);
    localparam logic [3:0] WR_CNT   = 4'(WR_WS);
    localparam logic [3:0] TURN_CNT = 4'((TURN > 0) ? (TURN - 1) : 0);
    localparam state_t     POST_ACC = (TURN == 0) ? S_IDLE : S_TURN;

    state_t        state, state_d;
    logic [3:0]    cnt, cnt_d;
    logic [AW-1:0] addr_d;
    logic          dq_oe, dq_oe_d;
    logic [DW-1:0] dq_out, dq_out_d;
    logic [BW-1:0] we_n_d, rd_n_d;
    logic [BW-1:0] bsel_q, bsel_d;
    logic [DW-1:0] rddata_d;
    logic          ack_d, rd_valid_d, busy_d;

    assign sram_dq = dq_oe ? dq_out : {DW{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sram_addr <= '0;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            sram_we_n <= '1;
            sram_rd_n <= '1;
            bsel_q    <= '0;
            rddata    <= '0;
            ack       <= 1'b0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sram_addr <= addr_d;
            dq_oe     <= dq_oe_d;
            dq_out    <= dq_out_d;
            sram_we_n <= we_n_d;
            sram_rd_n <= rd_n_d;
            bsel_q    <= bsel_d;
            rddata    <= rddata_d;
            ack       <= ack_d;
            rd_valid  <= rd_valid_d;
            busy      <= busy_d;
        end
    end

    // Next-state logic computes the next value of every output register.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        addr_d     = sram_addr;
        dq_oe_d    = dq_oe;
        dq_out_d   = dq_out;
        we_n_d     = sram_we_n;
        rd_n_d     = sram_rd_n;
        bsel_d     = bsel_q;
        rddata_d   = rddata;
        ack_d      = 1'b0;
        rd_valid_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (cyc && req) begin
                    ack_d  = 1'b1;
                    addr_d = addr;
                    bsel_d = bsel;
                    if (rnw) begin
                        state_d = S_RD;
                        rd_n_d  = '0;
                        cnt_d   = RD_CNT;
                    end else begin
                        state_d  = S_WSETUP;
                        dq_oe_d  = 1'b1;
                        dq_out_d = wrdata;
                    end
                end
            end
            S_RD: begin
                if (cnt == 4'd0) begin
                    rddata_d   = sram_dq;
                    rd_valid_d = 1'b1;
                    rd_n_d     = '1;
                    state_d    = POST_ACC;
                    cnt_d      = TURN_CNT;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_WSETUP: begin
                we_n_d  = ~bsel_q;
                cnt_d   = WR_CNT;
                state_d = S_WPULSE;
            end
            S_WPULSE: begin
                if (cnt == 4'd0) begin
                    we_n_d  = '1;
                    state_d = S_WHOLD;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            // Data stays driven one cycle past WE so the SRAM sees a clean hold.
            S_WHOLD: begin
                dq_oe_d = 1'b0;
                state_d = POST_ACC;
                cnt_d   = TURN_CNT;
            end
            S_TURN: begin
                if (cnt == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_sram_ctrl_ws.sv
// Directed bench for sram_ctrl_ws: default build (a), TURN=0/RD_WS=0 build (b), 32-bit build (c).
// Per-cycle activity is gathered at the falling edge into a small per-instance record.
module tb_sram_ctrl_ws;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic        a_cyc = 0, a_req = 0, a_rnw = 0;
    logic [20:0] a_addr = '0;
    logic [15:0] a_wrdata = '0, a_rddata, a_pat = '0;
    logic [1:0]  a_bsel = '0, a_we_n, a_rd_n;
    logic        a_ack, a_rd_valid, a_busy;
    logic [20:0] a_sram_addr;
    wire  [15:0] a_dq;

    logic        b_cyc = 0, b_req = 0, b_rnw = 0;
    logic [20:0] b_addr = '0;
    logic [15:0] b_wrdata = '0, b_rddata, b_pat = '0;
    logic [1:0]  b_bsel = '0, b_we_n, b_rd_n;
    logic        b_ack, b_rd_valid, b_busy;
    logic [20:0] b_sram_addr;
    wire  [15:0] b_dq;

    logic        c_cyc = 0, c_req = 0, c_rnw = 0;
    logic [20:0] c_addr = '0;
    logic [31:0] c_wrdata = '0, c_rddata, c_pat = '0;
    logic [3:0]  c_bsel = '0, c_we_n, c_rd_n;
    logic        c_ack, c_rd_valid, c_busy;
    logic [20:0] c_sram_addr;
    wire  [31:0] c_dq;

    sram_ctrl_ws u_a (
        .clk(clk), .rst_n(rst_n), .cyc(a_cyc), .req(a_req), .rnw(a_rnw), .addr(a_addr),
        .wrdata(a_wrdata), .bsel(a_bsel), .ack(a_ack), .rd_valid(a_rd_valid), .rddata(a_rddata),
        .busy(a_busy), .sram_addr(a_sram_addr), .sram_dq(a_dq), .sram_we_n(a_we_n), .sram_rd_n(a_rd_n)
    );

    sram_ctrl_ws #(.RD_WS(0), .TURN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .cyc(b_cyc), .req(b_req), .rnw(b_rnw), .addr(b_addr),
        .wrdata(b_wrdata), .bsel(b_bsel), .ack(b_ack), .rd_valid(b_rd_valid), .rddata(b_rddata),
        .busy(b_busy), .sram_addr(b_sram_addr), .sram_dq(b_dq), .sram_we_n(b_we_n), .sram_rd_n(b_rd_n)
    );

    sram_ctrl_ws #(.DW(32), .RD_WS(5), .WR_WS(0)) u_c (
        .clk(clk), .rst_n(rst_n), .cyc(c_cyc), .req(c_req), .rnw(c_rnw), .addr(c_addr),
        .wrdata(c_wrdata), .bsel(c_bsel), .ack(c_ack), .rd_valid(c_rd_valid), .rddata(c_rddata),
        .busy(c_busy), .sram_addr(c_sram_addr), .sram_dq(c_dq), .sram_we_n(c_we_n), .sram_rd_n(c_rd_n)
    );

    // Behavioural SRAMs: drive data while any RD lane is low, store enabled lanes on each edge with WE low.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [31:0] mem_c [256];

    assign a_dq = (~&a_rd_n) ? mem_a[a_sram_addr[7:0]] : 16'hzzzz;
    assign b_dq = (~&b_rd_n) ? mem_b[b_sram_addr[7:0]] : 16'hzzzz;
    assign c_dq = (~&c_rd_n) ? mem_c[c_sram_addr[7:0]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_a[8'hCD] <= 16'hBEEF;
            mem_a[8'h10] <= 16'hAAAA;
            mem_b[8'h05] <= 16'hC0DE;
            mem_c[8'h03] <= 32'h0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!a_we_n[i]) mem_a[a_sram_addr[7:0]][8*i +: 8] <= a_dq[8*i +: 8];
                if (!b_we_n[i]) mem_b[b_sram_addr[7:0]][8*i +: 8] <= b_dq[8*i +: 8];
            end
            for (int i = 0; i < 4; i++) begin
                if (!c_we_n[i]) mem_c[c_sram_addr[7:0]][8*i +: 8] <= c_dq[8*i +: 8];
            end
        end
    end

    typedef struct {
        int idx, acks, ack_at, rv_at, rd_low, rd_last;
        int we_low, we_first, drv, drv_first, drv_last, busy;
        logic [7:0] we_val;
    } mon_t;

    mon_t mon [3];

    function automatic void clearMon(input int k);
        mon[k] = '{default: 0};
        mon[k].ack_at    = -1;
        mon[k].rv_at     = -1;
        mon[k].rd_last   = -1;
        mon[k].we_first  = -1;
        mon[k].drv_first = -1;
        mon[k].drv_last  = -1;
    endfunction

    function automatic void observe(input int k, input logic ack_v, input logic rv, input logic rd_low,
                                    input logic we_low, input logic [7:0] we_v, input logic drv,
                                    input logic busy_v);
        if (ack_v) begin
            mon[k].acks++;
            mon[k].ack_at = mon[k].idx;
        end
        if (rv) mon[k].rv_at = mon[k].idx;
        if (rd_low) begin
            mon[k].rd_low++;
            mon[k].rd_last = mon[k].idx;
        end
        if (we_low) begin
            if (mon[k].we_low == 0) mon[k].we_first = mon[k].idx;
            mon[k].we_low++;
            mon[k].we_val = we_v;
        end
        if (drv) begin
            if (mon[k].drv == 0) mon[k].drv_first = mon[k].idx;
            mon[k].drv++;
            mon[k].drv_last = mon[k].idx;
        end
        if (busy_v) mon[k].busy++;
        mon[k].idx++;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample every instance mid-cycle, then land just after the next rising edge.
    task automatic step();
        @(negedge clk);
        observe(0, a_ack, a_rd_valid, ~&a_rd_n, ~&a_we_n, 8'(~a_we_n & 2'b11) == 8'h0 ? 8'(a_we_n) : 8'(a_we_n),
                a_dq === a_pat, a_busy);
        observe(1, b_ack, b_rd_valid, ~&b_rd_n, ~&b_we_n, 8'(b_we_n), b_dq === b_pat, b_busy);
        observe(2, c_ack, c_rd_valid, ~&c_rd_n, ~&c_we_n, 8'(c_we_n), c_dq === c_pat, c_busy);
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) step();
    endtask

    // Presents a request with cyc held high until ack appears; returns just after the accepting edge.
    task automatic applyStimulus(input int k, input logic rnw, input logic [20:0] addr,
                                 input logic [31:0] data, input logic [3:0] bsel, input bit clear);
        logic got;
        got = 1'b0;
        case (k)
            0: begin
                a_cyc = 1; a_req = 1; a_rnw = rnw; a_addr = addr; a_wrdata = data[15:0]; a_bsel = bsel[1:0];
                if (!rnw) a_pat = data[15:0];
            end
            1: begin
                b_cyc = 1; b_req = 1; b_rnw = rnw; b_addr = addr; b_wrdata = data[15:0]; b_bsel = bsel[1:0];
                if (!rnw) b_pat = data[15:0];
            end
            default: begin
                c_cyc = 1; c_req = 1; c_rnw = rnw; c_addr = addr; c_wrdata = data; c_bsel = bsel;
                if (!rnw) c_pat = data;
            end
        endcase
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = (k == 0) ? a_ack : (k == 1) ? b_ack : c_ack;
        end
        a_cyc = 0; a_req = 0; b_cyc = 0; b_req = 0; c_cyc = 0; c_req = 0;
        if (!got) checkOutput("ack_timeout", 32'(got), 32'd1);
        if (clear) clearMon(k);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) clearMon(k);

        // Reset values while rst_n is held low
        waitCycles(3);
        checkOutput("rst_we_n", 32'(a_we_n), 32'h3);
        checkOutput("rst_rd_n", 32'(a_rd_n), 32'h3);
        checkOutput("rst_busy", 32'(a_busy), 32'h0);
        checkOutput("rst_ack", 32'(a_ack), 32'h0);
        checkOutput("rst_rddata", 32'(a_rddata), 32'h0);
        checkOutput("rst_addr", 32'(a_sram_addr), 32'h0);
        checkOutput("rst_c_we_n", 32'(c_we_n), 32'hF);
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] default read");
        applyStimulus(0, 1'b1, 21'h1ABCD, 32'h0, 4'h0, 1'b1);
        waitCycles(8);
        checkOutput("rd_ack_at", mon[0].ack_at, 32'd0);
        checkOutput("rd_acks", mon[0].acks, 32'd1);
        checkOutput("rd_low_cycles", mon[0].rd_low, 32'd3);
        checkOutput("rd_valid_at", mon[0].rv_at, 32'd3);
        checkOutput("rd_data", 32'(a_rddata), 32'hBEEF);
        checkOutput("rd_busy", mon[0].busy, 32'd4);

        $display("[TB] default write, upper lane only");
        applyStimulus(0, 1'b0, 21'h00010, 32'h1234, 4'b0010, 1'b1);
        waitCycles(8);
        checkOutput("wr_drive_cycles", mon[0].drv, 32'd4);
        checkOutput("wr_drive_first", mon[0].drv_first, 32'd0);
        checkOutput("wr_drive_last", mon[0].drv_last, 32'd3);
        checkOutput("wr_we_cycles", mon[0].we_low, 32'd2);
        checkOutput("wr_we_first", mon[0].we_first, 32'd1);
        checkOutput("wr_we_value", 32'(mon[0].we_val), 32'h1);
        checkOutput("wr_busy", mon[0].busy, 32'd5);
        checkOutput("wr_mem", 32'(mem_a[8'h10]), 32'h12AA);
        checkOutput("wr_addr", 32'(a_sram_addr), 32'h10);

        $display("[TB] write with no lanes enabled");
        applyStimulus(0, 1'b0, 21'h00011, 32'h5A5A, 4'b0000, 1'b1);
        waitCycles(8);
        checkOutput("wr0_acks", mon[0].acks, 32'd1);
        checkOutput("wr0_we_cycles", mon[0].we_low, 32'd0);
        checkOutput("wr0_drive_cycles", mon[0].drv, 32'd4);
        checkOutput("wr0_busy", mon[0].busy, 32'd5);

        $display("[TB] reset during write pulse");
        applyStimulus(0, 1'b0, 21'h00020, 32'h5678, 4'b0011, 1'b1);
        step();
        checkOutput("mid_we_low", 32'(a_we_n), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_we_n", 32'(a_we_n), 32'h3);
        checkOutput("mid_rst_busy", 32'(a_busy), 32'h0);
        checkOutput("mid_rst_rddata", 32'(a_rddata), 32'h0);
        checkOutput("mid_rst_dq_driven", 32'(a_dq === 16'h5678), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("mid_rst_hold_we_n", 32'(a_we_n), 32'h3);

        $display("[TB] request held with cyc low");
        clearMon(0);
        a_req = 1; a_rnw = 1; a_addr = 21'h1ABCD; a_cyc = 0;
        waitCycles(5);
        a_cyc = 1;
        step();
        a_cyc = 0;
        waitCycles(1);
        a_req = 0;
        waitCycles(8);
        checkOutput("gate_acks", mon[0].acks, 32'd1);
        checkOutput("gate_ack_at", mon[0].ack_at, 32'd6);
        checkOutput("gate_rv_at", mon[0].rv_at, 32'd9);
        checkOutput("gate_rddata", 32'(a_rddata), 32'hBEEF);

        $display("[TB] back-to-back read then write, TURN=0 RD_WS=0");
        applyStimulus(1, 1'b1, 21'h00005, 32'h0, 4'h0, 1'b1);
        applyStimulus(1, 1'b0, 21'h00006, 32'h9ABC, 4'b0011, 1'b0);
        waitCycles(8);
        checkOutput("b2b_rv_at", mon[1].rv_at, 32'd1);
        checkOutput("b2b_rd_low", mon[1].rd_low, 32'd1);
        checkOutput("b2b_rd_last", mon[1].rd_last, 32'd0);
        checkOutput("b2b_acks", mon[1].acks, 32'd2);
        checkOutput("b2b_wr_ack_at", mon[1].ack_at, 32'd2);
        checkOutput("b2b_drive_first", mon[1].drv_first, 32'd2);
        checkOutput("b2b_drive_cycles", mon[1].drv, 32'd4);
        checkOutput("b2b_busy", mon[1].busy, 32'd5);
        checkOutput("b2b_rddata", 32'(b_rddata), 32'hC0DE);
        checkOutput("b2b_mem", 32'(mem_b[8'h06]), 32'h9ABC);
        checkOutput("b2b_addr", 32'(b_sram_addr), 32'h6);

        $display("[TB] 32-bit build, RD_WS=5 WR_WS=0");
        applyStimulus(2, 1'b0, 21'h00003, 32'hDEADBEEF, 4'b0101, 1'b1);
        waitCycles(6);
        checkOutput("w32_we_cycles", mon[2].we_low, 32'd1);
        checkOutput("w32_we_first", mon[2].we_first, 32'd1);
        checkOutput("w32_we_value", 32'(mon[2].we_val), 32'hA);
        checkOutput("w32_drive_cycles", mon[2].drv, 32'd3);
        checkOutput("w32_busy", mon[2].busy, 32'd4);
        checkOutput("w32_mem", mem_c[8'h03], 32'h00AD00EF);
        applyStimulus(2, 1'b1, 21'h00003, 32'h0, 4'h0, 1'b1);
        waitCycles(10);
        checkOutput("r32_rv_at", mon[2].rv_at, 32'd6);
        checkOutput("r32_rd_low", mon[2].rd_low, 32'd6);
        checkOutput("r32_busy", mon[2].busy, 32'd7);
        checkOutput("r32_rddata", c_rddata, 32'h00AD00EF);
        checkOutput("r32_addr", 32'(c_sram_addr), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
